mac_feed_fifo_bank: RTL and testbench

Receiving end of the weight-fetch path: one FIFO per MAC, written by the fetch arbiter's one-hot `wr_en` strobes with data returned from the weight memory, and drained by the MACs. It aligns the arbiter's write strobes to memory read latency and produces the `full` back-pressure the arbiter stalls on. It also reports when the whole fetch has been consumed.

---
 rtl/mac_feed_fifo_bank.sv | 232 +++++++++++++++++++++++
 tb/tb_mac_feed_fifo_bank.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_feed_fifo_bank.sv
// mac_feed_fifo_bank
//   Receive side of the weight-fetch path. The fetch arbiter sends one-hot
//   wr_en strobes. Each strobe is delayed by MEM_LATENCY cycles so that it
//   lines up with the mem_data returned for it. The word is then pushed into
//   the FIFO of the selected MAC. Each FIFO is first-word-fall-through and is
//   drained by its MAC.
//
//   Ports
//     clk, rst         single clock; asynchronous active-high reset
//     wr_en, addr      arbiter write strobe (one-hot) and fetch address
//     fetch_en         arbiter fetch strobe, used only for error checking
//     all_done         arbiter has issued every address
//     mem_data         read data, valid MEM_LATENCY cycles after wr_en
//     full             registered back-pressure to the arbiter
//     rd_en            per-MAC pop request
//     rd_data          per-MAC head word; FIFO i at [i*DATA_WIDTH +: DATA_WIDTH]
//     empty            per-FIFO empty flag
//     drained          fetch complete and every FIFO consumed
//     overflow         sticky: multi-hot / unqualified strobe, or write to a full FIFO
//     underflow        sticky: pop of an empty FIFO
//
//   Optional feature (macro MACFIFO_ADDR_TAG_EN): each entry also stores the
//   delayed fetch address, and the rd_addr output shows it per head word.

// One FIFO lane. It holds the storage and the pointers, and keeps the
// reservation count: entries held plus writes still in the latency pipe.
module mac_feed_fifo_lane #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int RW         = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wr_data,
`ifdef MACFIFO_ADDR_TAG_EN
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
`endif
  input  logic                  rd_en,
  input  logic                  inc,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic [RW-1:0]         resv_next,
  output logic                  wr_drop,
  output logic                  rd_under
);
  localparam int IW = $clog2(FIFO_DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, occ;
  logic [RW-1:0]         resv_q, resv_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
`ifdef MACFIFO_ADDR_TAG_EN
  logic [ADDR_WIDTH-1:0] tag_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] tag_d [FIFO_DEPTH];
`endif
  logic empty_c, full_c, pop, push, drop;

  always_comb begin
    occ     = wr_ptr_q - rd_ptr_q;
    empty_c = (occ == '0);
    full_c  = (occ == PW'(FIFO_DEPTH));
    pop     = rd_en & ~empty_c;
    // The pop frees a slot at the same edge, so a write to a full FIFO is
    // accepted when it coincides with a pop.
    push    = wr & (~full_c | pop);
    drop    = wr & full_c & ~pop;
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    mem_d    = mem_q;
    if (push) mem_d[wr_ptr_q[IW-1:0]] = wr_data;
`ifdef MACFIFO_ADDR_TAG_EN
    tag_d = tag_q;
    if (push) tag_d[wr_ptr_q[IW-1:0]] = wr_addr;
`endif
    // A dropped write leaves the pipe without becoming an entry, so its
    // reservation is returned.
    resv_d = resv_q + RW'(inc) - RW'(pop) - RW'(drop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      resv_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      resv_q   <= resv_d;
    end
  end

  // Storage is not reset; pointer reset makes old contents unreachable.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
`ifdef MACFIFO_ADDR_TAG_EN
    tag_q <= tag_d;
`endif
  end

  assign empty     = empty_c;
  assign rd_data   = empty_c ? '0 : mem_q[rd_ptr_q[IW-1:0]];
`ifdef MACFIFO_ADDR_TAG_EN
  assign rd_addr   = empty_c ? '0 : tag_q[rd_ptr_q[IW-1:0]];
`endif
  assign resv_next = resv_d;
  assign wr_drop   = drop;
  assign rd_under  = rd_en & empty_c;
endmodule

module mac_feed_fifo_bank #(
  parameter int NUM_MACS    = 4,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int MEM_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_MACS-1:0]            wr_en,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic                           fetch_en,
  input  logic                           all_done,
  input  logic [DATA_WIDTH-1:0]          mem_data,
  output logic                           full,
  input  logic [NUM_MACS-1:0]            rd_en,
  output logic [NUM_MACS*DATA_WIDTH-1:0] rd_data,
`ifdef MACFIFO_ADDR_TAG_EN
  output logic [NUM_MACS*ADDR_WIDTH-1:0] rd_addr,
`endif
  output logic [NUM_MACS-1:0]            empty,
  output logic                           drained,
  output logic                           overflow,
  output logic                           underflow
);
  // Room for DEPTH entries plus MEM_LATENCY in flight, with margin.
  localparam int RW = $clog2(FIFO_DEPTH + MEM_LATENCY + 1) + 1;
  localparam logic [RW-1:0] FULL_THR = RW'(FIFO_DEPTH - 2);

  logic [MEM_LATENCY-1:0][NUM_MACS-1:0]   wr_pipe_q, wr_pipe_d;
  logic [NUM_MACS-1:0]                    wr_dly;
  logic [NUM_MACS-1:0][RW-1:0]            lane_resv;
  logic [NUM_MACS-1:0]                    lane_drop, lane_under;
  logic full_q, full_d, drained_q, drained_d;
  logic ovf_q, ovf_d, udf_q, udf_d;
  logic multi_hot, stray;

`ifdef MACFIFO_ADDR_TAG_EN
  logic [MEM_LATENCY-1:0][ADDR_WIDTH-1:0] addr_pipe_q, addr_pipe_d;
  logic [ADDR_WIDTH-1:0]                  addr_dly;
  assign addr_dly = addr_pipe_q[MEM_LATENCY-1];
`else
  logic unused_addr;
  assign unused_addr = ^addr;
`endif

  assign wr_dly = wr_pipe_q[MEM_LATENCY-1];

  always_comb begin
    wr_pipe_d    = '0;
    wr_pipe_d[0] = wr_en;
    for (int s = 1; s < MEM_LATENCY; s++) wr_pipe_d[s] = wr_pipe_q[s-1];
`ifdef MACFIFO_ADDR_TAG_EN
    addr_pipe_d    = '0;
    addr_pipe_d[0] = addr;
    for (int s = 1; s < MEM_LATENCY; s++) addr_pipe_d[s] = addr_pipe_q[s-1];
`endif
    // x & (x-1) is nonzero iff more than one bit is set.
    multi_hot = |(wr_en & (wr_en - NUM_MACS'(1)));
    stray     = (|wr_en) & ~fetch_en;
    full_d    = 1'b0;
    for (int i = 0; i < NUM_MACS; i++)
      if (lane_resv[i] >= FULL_THR) full_d = 1'b1;
    ovf_d = ovf_q | multi_hot | stray | (|lane_drop);
    udf_d = udf_q | (|lane_under);
    // A new strobe clears drained at the same edge it is sampled.
    drained_d = all_done & (&empty) & ~(|wr_pipe_q) & ~(|wr_en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_pipe_q <= '0;
`ifdef MACFIFO_ADDR_TAG_EN
      addr_pipe_q <= '0;
`endif
      full_q    <= 1'b0;
      drained_q <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wr_pipe_q <= wr_pipe_d;
`ifdef MACFIFO_ADDR_TAG_EN
      addr_pipe_q <= addr_pipe_d;
`endif
      full_q    <= full_d;
      drained_q <= drained_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  for (genvar i = 0; i < NUM_MACS; i++) begin : g_lane
    mac_feed_fifo_lane #(
      .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH), .RW(RW)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .wr       (wr_dly[i]),
      .wr_data  (mem_data),
`ifdef MACFIFO_ADDR_TAG_EN
      .wr_addr  (addr_dly),
      .rd_addr  (rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
`endif
      .rd_en    (rd_en[i]),
      .inc      (wr_en[i]),
      .rd_data  (rd_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .empty    (empty[i]),
      .resv_next(lane_resv[i]),
      .wr_drop  (lane_drop[i]),
      .rd_under (lane_under[i])
    );
  end

  assign full      = full_q;
  assign drained   = drained_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;
endmodule

// File: tb/tb_mac_feed_fifo_bank.sv
module tb_mac_feed_fifo_bank;
  localparam int N = 4, AW = 8, DW = 16, D = 8, LAT = 1;

  logic clk = 1'b0;
  logic rst, fetch_en, all_done, full, drained, overflow, underflow;
  logic [N-1:0]    wr_en, rd_en, empty;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   mem_data;
  logic [N*DW-1:0] rd_data;
`ifdef MACFIFO_ADDR_TAG_EN
  logic [N*AW-1:0] rd_addr;
`endif

  mac_feed_fifo_bank #(.NUM_MACS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                       .FIFO_DEPTH(D), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .addr(addr), .fetch_en(fetch_en),
    .all_done(all_done), .mem_data(mem_data), .full(full), .rd_en(rd_en),
    .rd_data(rd_data),
`ifdef MACFIFO_ADDR_TAG_EN
    .rd_addr(rd_addr),
`endif
    .empty(empty), .drained(drained), .overflow(overflow), .underflow(underflow));

  always #5 clk = ~clk;

  // Reference model: one queue per MAC, a queue of strobes waiting for memory.
  logic [DW-1:0] mq[N][$];
  logic [N-1:0]  pend[$];
  logic [AW-1:0] ahist[$];
  bit m_ovf, m_udf, m_full, m_drained;
  int checks = 0, errors = 0;

  function automatic logic [DW-1:0] mdata(logic [AW-1:0] a);
    return {a ^ 8'hC3, a};
  endfunction

  function automatic logic [DW-1:0] head(int i);
    return rd_data[i*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] mfront(int i);
    return (mq[i].size() == 0) ? '0 : mq[i][0];
  endfunction

  function automatic bit model_empty();
    for (int i = 0; i < N; i++) if (mq[i].size() != 0) return 0;
    foreach (pend[k]) if (pend[k] != 0) return 0;
    return 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    pend.delete(); ahist.delete();
    m_ovf = 0; m_udf = 0; m_full = 0; m_drained = 0;
  endtask

  task automatic model_edge();
    bit nd, popped;
    int pre, r;
    logic [N-1:0] wmask;
    nd = all_done && model_empty() && (wr_en == '0);
    wmask = '0;
    if (pend.size() == LAT) wmask = pend.pop_front();
    for (int i = 0; i < N; i++) begin
      pre = mq[i].size();
      popped = rd_en[i] && pre > 0;
      if (rd_en[i] && pre == 0) m_udf = 1;
      if (popped) void'(mq[i].pop_front());
      if (wmask[i]) begin
        if (pre < D || popped) mq[i].push_back(mem_data);
        else m_ovf = 1;
      end
    end
    pend.push_back(wr_en);
    if ($countones(wr_en) > 1 || (wr_en != '0 && !fetch_en)) m_ovf = 1;
    m_full = 0;
    for (int i = 0; i < N; i++) begin
      r = mq[i].size();
      foreach (pend[k]) r += int'(pend[k][i]);
      if (r >= D - 2) m_full = 1;
    end
    m_drained = nd;
  endtask

  // One clock: the model takes the inputs sampled at the edge, then the memory
  // returns the data for the address sampled LAT edges ago.
  task automatic step();
    @(posedge clk);
    model_edge();
    ahist.push_back(addr);
    #1;
    if (ahist.size() >= LAT) mem_data = mdata(ahist.pop_front());
  endtask

  task automatic issue(int i, int a);
    wr_en = N'(1) << i; addr = AW'(a); fetch_en = 1;
  endtask

  task automatic idle();
    wr_en = '0; rd_en = '0; fetch_en = 0;
  endtask

  task automatic drain_all();
    idle();
    repeat (LAT) step();
    for (int k = 0; k < 4 * D + 4; k++) begin
      rd_en = ~empty;
      if (rd_en == '0) break;
      step();
    end
    rd_en = '0;
  endtask

  task automatic test_reset();
    rst = 1; idle(); all_done = 0; addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    checks++; if (empty !== '1) begin errors++; $display("FAIL reset_empty: got %b want %b", empty, {N{1'b1}}); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (drained !== 1'b0) begin errors++; $display("FAIL reset_drained: got %b want 0", drained); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_sticky: got %b%b want 00", overflow, underflow); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    rst = 0;
  endtask

  task automatic test_round_robin();
    for (int c = 0; c < 32; c++) begin
      issue(c % N, c);
      step();
      checks++; if (full !== m_full) begin errors++; $display("FAIL rr_full c=%0d: got %b want %b", c, full, m_full); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rr_overflow c=%0d: got %b want 0", c, overflow); end
    end
    idle();
    repeat (LAT) step();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < D; k++) begin
        checks++; if (head(i) !== mdata(AW'(N * k + i)) || empty[i] !== 1'b0) begin
          errors++; $display("FAIL rr_data f=%0d k=%0d: got %h empty=%b want %h", i, k, head(i), empty[i], mdata(AW'(N * k + i)));
        end
        rd_en = N'(1) << i; step(); rd_en = '0;
      end
    checks++; if (empty !== '1 || full !== 1'b0) begin errors++; $display("FAIL rr_end: got empty=%b full=%b want %b 0", empty, full, {N{1'b1}}); end
  endtask

  task automatic test_back_pressure();
    int a = 0, exp0 = 0;
    for (int c = 0; c < 180; c++) begin
      if (!full) begin issue(a % N, a); a++; end
      else begin wr_en = '0; fetch_en = 0; end
      rd_en = '0;
      rd_en[0] = (c % 3 == 0) && !empty[0];
      for (int j = 1; j < N; j++) rd_en[j] = $urandom_range(1) == 1 && !empty[j];
      if (rd_en[0]) begin
        checks++; if (head(0) !== mdata(AW'(exp0))) begin errors++; $display("FAIL bp_seq: got %h want %h", head(0), mdata(AW'(exp0))); end
        exp0 += 4;
      end
      step();
      checks++; if (overflow !== 1'b0 || full !== m_full) begin errors++; $display("FAIL bp_flags c=%0d: got ovf=%b full=%b want 0 %b", c, overflow, full, m_full); end
    end
    drain_all();
  endtask

  task automatic test_full_simul();
    for (int k = 0; k < D; k++) begin issue(2, 8'h40 + k); step(); end
    issue(2, 8'h50); step();
    idle(); rd_en = 4'b0100; step();
    rd_en = '0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_overflow: got %b want 0", overflow); end
    for (int k = 0; k < D; k++) begin
      logic [AW-1:0] ea;
      ea = (k < D - 1) ? AW'(8'h41 + k) : 8'h50;
      checks++; if (head(2) !== mdata(ea) || empty[2] !== 1'b0) begin
        errors++; $display("FAIL simul_data k=%0d: got %h empty=%b want %h", k, head(2), empty[2], mdata(ea));
      end
      rd_en = 4'b0100; step(); rd_en = '0;
    end
    checks++; if (empty[2] !== 1'b1) begin errors++; $display("FAIL simul_occ: got empty=%b want 1 after %0d pops", empty[2], D); end
  endtask

  task automatic test_ovf_udf();
    for (int k = 0; k < D; k++) begin issue(1, 8'h60 + k); step(); end
    idle(); step();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ou_pre: got %b want 0", overflow); end
    issue(1, 8'h70); step(); idle(); step();
    checks++; if (overflow !== 1'b1 || m_ovf !== 1'b1) begin errors++; $display("FAIL ou_overflow: got %b want 1", overflow); end
    rd_en = 4'b1000; step(); rd_en = '0;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL ou_underflow: got %b want 1", underflow); end
    repeat (5) step();
    checks++; if ({overflow, underflow} !== 2'b11) begin errors++; $display("FAIL ou_sticky: got %b%b want 11", overflow, underflow); end
    for (int k = 0; k < D; k++) begin
      checks++; if (head(1) !== mdata(AW'(8'h60 + k))) begin errors++; $display("FAIL ou_contents k=%0d: got %h want %h", k, head(1), mdata(AW'(8'h60 + k))); end
      rd_en = 4'b0010; step(); rd_en = '0;
    end
    checks++; if (empty[1] !== 1'b1) begin errors++; $display("FAIL ou_empty: got %b want 1", empty[1]); end
    // Multi-hot strobe: flagged, but both FIFOs take the word.
    test_reset();
    wr_en = 4'b0011; addr = 8'h99; fetch_en = 1; step(); idle(); step();
    checks++; if (overflow !== 1'b1 || head(0) !== mdata(8'h99) || head(1) !== mdata(8'h99)) begin
      errors++; $display("FAIL ou_multihot: got ovf=%b h0=%h h1=%h want 1 %h", overflow, head(0), head(1), mdata(8'h99));
    end
    // Strobe without fetch_en is flagged too.
    test_reset();
    wr_en = 4'b0001; addr = 8'h12; fetch_en = 0; step(); idle(); step();
    checks++; if (overflow !== 1'b1 || head(0) !== mfront(0)) begin errors++; $display("FAIL ou_stray: got ovf=%b h0=%h want 1 %h", overflow, head(0), mfront(0)); end
    test_reset();
  endtask

  task automatic test_drain();
    int a = 0, budget = 0;
    bit was_empty;
    all_done = 0;
    while (a < 256 && budget < 3000) begin
      budget++;
      if (!full) begin issue(a % N, a); a++; end
      else begin wr_en = '0; fetch_en = 0; end
      for (int j = 0; j < N; j++) rd_en[j] = $urandom_range(1) == 1 && !empty[j];
      for (int j = 0; j < N; j++) if (rd_en[j] && head(j) !== mfront(j)) begin
        checks++; errors++; $display("FAIL dr_data f=%0d: got %h want %h", j, head(j), mfront(j));
      end
      step();
      checks++; if (drained !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL dr_fill: got drained=%b ovf=%b want 0 0", drained, overflow); end
    end
    if (a < 256) begin checks++; errors++; $display("FAIL dr_timeout: issued %0d want 256", a); end
    idle(); all_done = 1;
    was_empty = 0;
    for (int c = 0; c < 400 && !was_empty; c++) begin
      for (int j = 0; j < N; j++) rd_en[j] = $urandom_range(3) != 0 && !empty[j];
      step();
      was_empty = model_empty();
      checks++; if (drained !== m_drained) begin errors++; $display("FAIL dr_track: got %b want %b", drained, m_drained); end
    end
    rd_en = '0;
    checks++; if (!was_empty || drained !== 1'b0) begin errors++; $display("FAIL dr_early: got drained=%b empty_reached=%0d want 0 1", drained, was_empty); end
    step();
    checks++; if (drained !== 1'b1) begin errors++; $display("FAIL dr_rise: got %b want 1", drained); end
    repeat (3) step();
    checks++; if (drained !== 1'b1) begin errors++; $display("FAIL dr_hold: got %b want 1", drained); end
    issue(3, 8'hEE); step(); idle();
    checks++; if (drained !== 1'b0) begin errors++; $display("FAIL dr_newwr: got %b want 0", drained); end
    drain_all(); step();
    checks++; if (drained !== 1'b1) begin errors++; $display("FAIL dr_again: got %b want 1", drained); end
    all_done = 0; step();
    checks++; if (drained !== 1'b0) begin errors++; $display("FAIL dr_alldone_low: got %b want 0", drained); end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 6; c++) begin issue(c % N, 8'hA0 + c); step(); end
    #2 rst = 1;
    model_reset();
    #1;
    checks++; if (empty !== '1 || full !== 1'b0 || rd_data !== '0 || drained !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got empty=%b full=%b rd=%h drained=%b want %b 0 0 0", empty, full, rd_data, drained, {N{1'b1}});
    end
    idle();
    repeat (2) @(posedge clk);
    #2 rst = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (empty !== '1 || rd_data !== '0) begin errors++; $display("FAIL mid_stale c=%0d: got empty=%b rd=%h want %b 0", c, empty, rd_data, {N{1'b1}}); end
    end
  endtask

  initial begin
    rst = 0; wr_en = '0; rd_en = '0; addr = '0; fetch_en = 0; all_done = 0; mem_data = '0;
    #1;
    test_reset();
    test_round_robin();
    test_back_pressure();
    test_full_simul();
    test_ovf_udf();
    test_drain();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
